tof_poll_ctrl: RTL
==================

# tof_poll_ctrl

Polling scheduler for the TOF10120 range-sensor UART link. While enabled, it periodically sends the three-byte read command "r6#" through the uart_tx byte handshake. It then opens a receive window and waits for the sensor's LF-terminated reply, reporting completion, timeout or overlong frames. It sits between uart_rx/uart_tx and ascii_control: its `rx_gate` qualifies ascii_control's `pi_sig`, so only reply bytes reach the distance parser.

## Interface
- `clk_fre`, 50_000_000, system clock frequency in Hz.
- `UART_BPS`, 9600, UART baud rate.
- `POLL_CYC`, 5_000_000, poll period in clk cycles (100 ms).
- `TO_CYC`, 2_500_000, reply timeout in clk cycles, counted from entry to WAIT_RSP.
- `MAX_RSP`, 16, maximum reply bytes accepted before the LF.
- Derived: `GAP_CYC` = 11 × (clk_fre / UART_BPS), integer division. Default 57_288 (one frame plus one stop-bit margin).
- `clk`  input  1  system clock.
- `rst`  input  1  reset, asynchronous, active-high.
- `en`  input  1  polling enable, level.
- `rx_data`  input  8  byte from uart_rx `po_data`.
- `rx_sig`  input  1  one-cycle strobe from uart_rx `po_sig`.
- `tx_data`  output  8  byte to uart_tx `pi_data`, registered.
- `tx_sig`  output  1  one-cycle strobe to uart_tx `pi_sig`, registered.
- `rx_gate`  output  1  high while in WAIT_RSP; ANDed with `rx_sig` to drive ascii_control `pi_sig`.
- `busy`  output  1  high in any state other than IDLE.
- `frame_done`  output  1  one-cycle pulse: reply completed with LF.
- `timeout`  output  1  one-cycle pulse: no LF within TO_CYC.
- `overrun`  output  1  one-cycle pulse: MAX_RSP bytes received without LF.
- `err_cnt`  output  8  count of timeout plus overrun events, saturating at 255.

## Operation
- States: IDLE, SEND, GAP, WAIT_RSP.
- Poll counter:
  - Counts 0..POLL_CYC-1 and wraps while `en`=1.
  - Held at 0 while `en`=0.
  - Runs in every state.
- IDLE → SEND when the poll counter equals POLL_CYC-1 and `en`=1. Byte index is set to 0.
- If a wrap occurs outside IDLE, that poll is skipped silently. The next wrap is used.
- SEND:
  - Drives `tx_data` = cmd[idx], where cmd = 0x72, 0x36, 0x23.
  - Pulses `tx_sig` for one cycle.
  - Goes to GAP.
- GAP:
  - Waits exactly GAP_CYC cycles.
  - If idx<2: idx++ and go to SEND.
  - If idx=2: go to WAIT_RSP, clearing the timeout counter and the byte counter.
- WAIT_RSP, on each `rx_sig`:
  - If `rx_data`=0x0A: pulse `frame_done` and go to IDLE.
  - Otherwise increment the byte count. When it reaches MAX_RSP, pulse `overrun`, increment `err_cnt` and go to IDLE.
- WAIT_RSP timeout: when the timeout counter reaches TO_CYC-1 without an LF, pulse `timeout`, increment `err_cnt` and go to IDLE.
- Simultaneous events:
  - An LF in the same cycle as timeout expiry counts as success: only `frame_done`, no error.
  - An LF on the MAX_RSP-th byte also counts as success.
- `rx_sig` outside WAIT_RSP is ignored: no counting, and `rx_gate`=0.
- `en` deasserted mid-transaction: the current transaction completes (the command is never truncated), then the block stays in IDLE.
- `tx_data` holds its last value between strobes.

## Timing
- Reset values: state IDLE; `tx_data`=0x00; `tx_sig`=0; `rx_gate`=0; `busy`=0; `frame_done`=0; `timeout`=0; `overrun`=0; `err_cnt`=0; all counters 0.
- Reset mid-operation aborts immediately. No further `tx_sig` is issued until a full poll period elapses after release.
- Poll-counter match at cycle T (in IDLE) produces `tx_sig` pulses at T+1, T+2+GAP_CYC and T+3+2·GAP_CYC.
- `rx_gate` and WAIT_RSP begin at cycle W = T+4+3·GAP_CYC.
- `timeout` is high in cycle W+TO_CYC, and `busy` is low from that same cycle.
- `frame_done` and `overrun` are high in the cycle after the qualifying `rx_sig`. `rx_gate` and `busy` drop in that same cycle.
- All status outputs are registered. There are no combinational paths from input to output.

## Test plan
All scenarios use clk_fre=1_000_000, UART_BPS=100_000 (GAP_CYC=110), POLL_CYC=2000, TO_CYC=500, MAX_RSP=16.

- **Command sequence:** hold `en`=1 from reset, no rx. Required:
  - `tx_sig` pulses at cycles 2000, 2111, 2222 with `tx_data` 0x72, 0x36, 0x23.
  - `rx_gate` rises at cycle 2333.
  - `timeout` pulses at cycle 2833.
  - `err_cnt`=1.
- **Good reply:** after the third byte, feed "L=0123mm" then 0x0D, 0x0A as `rx_sig` strobes 20 cycles apart. Required:
  - `frame_done` is a single pulse one cycle after the 0x0A strobe.
  - `err_cnt` stays 0.
  - Next command starts at cycle 4000.
- **Overrun:** feed 16 non-LF bytes in WAIT_RSP. Required:
  - `overrun` pulses after the 16th byte.
  - `err_cnt` increments by 1.
  - State returns to IDLE.
  - A 17th byte is ignored.
- **Tie:** deliver an LF strobe in cycle 2832, so `frame_done` and timeout expiry coincide. Required: `frame_done` only, no `timeout`, `err_cnt` unchanged.
- **Disable mid-transaction:** drop `en` at cycle 2050. Required:
  - Bytes 2 and 3 are still sent.
  - WAIT_RSP completes normally.
  - No `tx_sig` afterwards while `en`=0.
- **Saturation and reset:**
  - Run 300 polls with no reply. Required: `err_cnt`=255.
  - Then assert `rst` mid-GAP. Required: all outputs return to their reset values asynchronously, within the same cycle.

Source files
------------

// File: rtl/tof_poll_ctrl.sv
// -----------------------------------------------------------------------------
// tof_poll_ctrl
// Polling scheduler for the TOF10120 range-sensor UART link. While enabled it
// periodically sends the read command "r6#" byte by byte through the uart_tx
// strobe handshake. After the last byte it opens a receive window and waits
// for an LF-terminated reply, then reports completion, timeout or overrun.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   en         polling enable (level)
//   rx_data    received byte from uart_rx
//   rx_sig     one-cycle receive strobe from uart_rx
//   tx_data    byte to uart_tx, held between strobes
//   tx_sig     one-cycle transmit strobe to uart_tx
//   rx_gate    high while the receive window is open (qualifies ascii_control)
//   busy       high whenever a transaction is in progress
//   frame_done one-cycle pulse: LF-terminated reply received
//   timeout    one-cycle pulse: no LF within the reply window
//   overrun    one-cycle pulse: too many bytes without an LF
//   err_cnt    saturating count of timeout and overrun events
// All outputs are registered.
// -----------------------------------------------------------------------------
module tof_poll_ctrl #(
  parameter int clk_fre  = 50_000_000,
  parameter int UART_BPS = 9600,
  parameter int POLL_CYC = 5_000_000,
  parameter int TO_CYC   = 2_500_000,
  parameter int MAX_RSP  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] rx_data,
  input  logic       rx_sig,
  output logic [7:0] tx_data,
  output logic       tx_sig,
  output logic       rx_gate,
  output logic       busy,
  output logic       frame_done,
  output logic       timeout,
  output logic       overrun,
  output logic [7:0] err_cnt
);

  // One UART frame plus a stop-bit of margin between command bytes.
  localparam int GAP_CYC = 32'sd11 * (clk_fre / UART_BPS);

  localparam int PW = $clog2(POLL_CYC + 32'sd1);
  localparam int GW = $clog2(GAP_CYC + 32'sd1);
  localparam int TW = $clog2(TO_CYC + 32'sd1);
  localparam int BW = $clog2(MAX_RSP + 32'sd1);

  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYC - 32'sd1);
  localparam logic [PW-1:0] POLL_ONE  = PW'(32'sd1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 32'sd1);
  localparam logic [GW-1:0] GAP_ONE   = GW'(32'sd1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYC - 32'sd1);
  localparam logic [TW-1:0] TO_ONE    = TW'(32'sd1);
  localparam logic [BW-1:0] RSP_LAST  = BW'(MAX_RSP - 32'sd1);
  localparam logic [BW-1:0] RSP_ONE   = BW'(32'sd1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    GAP      = 2'd2,
    WAIT_RSP = 2'd3
  } state_t;

  // Command bytes "r6#".
  function automatic logic [7:0] cmd_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = 8'h72;
      2'd1:    b = 8'h36;
      2'd2:    b = 8'h23;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  state_t        state_r, state_s;
  logic [PW-1:0] poll_cnt_r;
  logic [GW-1:0] gap_cnt_r, gap_cnt_s;
  logic [TW-1:0] to_cnt_r, to_cnt_s;
  logic [BW-1:0] byte_cnt_r, byte_cnt_s;
  logic [1:0]    idx_r, idx_s;

  logic [7:0] tx_data_s;
  logic       tx_sig_s, rx_gate_s, busy_s;
  logic       frame_done_s, timeout_s, overrun_s, err_inc_s;

  // Free-running poll counter; held at zero while polling is disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      poll_cnt_r <= '0;
    end else if (!en) begin
      poll_cnt_r <= '0;
    end else if (poll_cnt_r == POLL_LAST) begin
      poll_cnt_r <= '0;
    end else begin
      poll_cnt_r <= poll_cnt_r + POLL_ONE;
    end
  end

  // FSM state and transaction counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      gap_cnt_r  <= '0;
      to_cnt_r   <= '0;
      byte_cnt_r <= '0;
      idx_r      <= 2'd0;
    end else begin
      state_r    <= state_s;
      gap_cnt_r  <= gap_cnt_s;
      to_cnt_r   <= to_cnt_s;
      byte_cnt_r <= byte_cnt_s;
      idx_r      <= idx_s;
    end
  end

  // Next-state logic and next values of the registered outputs.
  always_comb begin
    state_s      = state_r;
    gap_cnt_s    = gap_cnt_r;
    to_cnt_s     = to_cnt_r;
    byte_cnt_s   = byte_cnt_r;
    idx_s        = idx_r;
    frame_done_s = 1'b0;
    timeout_s    = 1'b0;
    overrun_s    = 1'b0;
    err_inc_s    = 1'b0;

    case (state_r)
      IDLE: begin
        // A wrap seen while busy is simply not acted on: that poll is skipped.
        if (en && (poll_cnt_r == POLL_LAST)) begin
          state_s = SEND;
          idx_s   = 2'd0;
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        state_s   = GAP;
        gap_cnt_s = '0;
      end
      GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          if (idx_r == 2'd2) begin
            state_s    = WAIT_RSP;
            to_cnt_s   = '0;
            byte_cnt_s = '0;
          end else begin
            state_s = SEND;
            idx_s   = idx_r + 2'd1;
          end
        end else begin
          gap_cnt_s = gap_cnt_r + GAP_ONE;
        end
      end
      WAIT_RSP: begin
        // LF is checked first so it wins over both overrun and timeout.
        if (rx_sig && (rx_data == 8'h0A)) begin
          frame_done_s = 1'b1;
          state_s      = IDLE;
        end else if (rx_sig && (byte_cnt_r == RSP_LAST)) begin
          overrun_s = 1'b1;
          err_inc_s = 1'b1;
          state_s   = IDLE;
        end else if (to_cnt_r == TO_LAST) begin
          timeout_s = 1'b1;
          err_inc_s = 1'b1;
          state_s   = IDLE;
        end else begin
          to_cnt_s = to_cnt_r + TO_ONE;
          if (rx_sig) begin
            byte_cnt_s = byte_cnt_r + RSP_ONE;
          end else begin
            byte_cnt_s = byte_cnt_r;
          end
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they align with it.
    tx_sig_s  = (state_s == SEND);
    rx_gate_s = (state_s == WAIT_RSP);
    busy_s    = (state_s != IDLE);
    if (tx_sig_s) begin
      tx_data_s = cmd_byte(idx_s);
    end else begin
      tx_data_s = tx_data;
    end
  end

  // Registered outputs and the saturating error counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data    <= 8'h00;
      tx_sig     <= 1'b0;
      rx_gate    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      timeout    <= 1'b0;
      overrun    <= 1'b0;
      err_cnt    <= 8'h00;
    end else begin
      tx_data    <= tx_data_s;
      tx_sig     <= tx_sig_s;
      rx_gate    <= rx_gate_s;
      busy       <= busy_s;
      frame_done <= frame_done_s;
      timeout    <= timeout_s;
      overrun    <= overrun_s;
      if (err_inc_s && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule
